// File: rtl/pu_inst_sequencer_pkg.sv
// Shared opcode values, instruction field locations and FSM encoding for the
// PU instruction sequencer and its decoder.
package pu_inst_sequencer_pkg;

    localparam int INST_W_DEF  = 16;
    localparam int INST_AW_DEF = 8;
    localparam int ROW_AW_DEF  = 4;

    localparam logic [3:0] FUNC_F     = 4'h0;
    localparam logic [3:0] FUNC_G     = 4'h1;
    localparam logic [3:0] FUNC_REP   = 4'h2;
    localparam logic [3:0] FUNC_SPC   = 4'h3;
    localparam logic [3:0] FUNC_RATE0 = 4'h4;
    localparam logic [3:0] FUNC_RATE1 = 4'h5;
    localparam logic [3:0] FUNC_TYPE1 = 4'h6;
    localparam logic [3:0] FUNC_TYPE3 = 4'h7;
    localparam logic [3:0] FUNC_COMB  = 4'h8;
    localparam logic [3:0] OP_NOP     = 4'hE;
    localparam logic [3:0] OP_END     = 4'hF;

    localparam int PU_OP_LOCATION      = 0;
    localparam int INST_STAGE_LOCATION = 4;
    localparam int SRC_ROW_LOCATION    = 7;
    localparam int DST_ROW_LOCATION    = 11;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_LOAD  = 3'd2,
        ST_EXEC  = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

endpackage

// File: rtl/pu_inst_sequencer_decode.sv
// Opcode classifier: which memory (if any) an instruction writes, and whether
// it terminates the program.
import pu_inst_sequencer_pkg::*;

module pu_inst_sequencer_decode (
    input  logic [3:0] opcode_i,
    output logic       llr_wr_o,
    output logic       bit_wr_o,
    output logic       is_end_o
);

    always_comb begin
        llr_wr_o = 1'b0;
        bit_wr_o = 1'b0;
        is_end_o = 1'b0;
        case (opcode_i)
            FUNC_F, FUNC_G: llr_wr_o = 1'b1;
            FUNC_REP, FUNC_SPC, FUNC_RATE0, FUNC_RATE1,
            FUNC_TYPE1, FUNC_TYPE3, FUNC_COMB: bit_wr_o = 1'b1;
            OP_END: is_end_o = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: rtl/pu_inst_sequencer.sv
// Walks the instruction ROM from pc=0, issuing one instruction at a time to the
// process unit: FETCH -> LOAD (LLR read) -> EXEC (write-back) until END or pc wrap.
import pu_inst_sequencer_pkg::*;

module pu_inst_sequencer #(
    parameter int INST_W  = INST_W_DEF,
    parameter int INST_AW = INST_AW_DEF,
    parameter int ROW_AW  = ROW_AW_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start_i,
    input  logic               hold_i,
    output logic               busy_o,
    output logic               done_o,
    output logic               err_o,
    output logic               inst_rd_en_o,
    output logic [INST_AW-1:0] inst_addr_o,
    input  logic [INST_W-1:0]  inst_rdata_i,
    output logic [INST_W-1:0]  pu_inst_o,
    output logic               llr_rd_en_o,
    output logic [ROW_AW-1:0]  llr_rd_addr_o,
    output logic               llr_wr_en_o,
    output logic               bit_wr_en_o,
    output logic [ROW_AW-1:0]  wr_addr_o,
    output logic [15:0]        frame_cnt_o
);

    state_t              state_q, state_d;
    logic [INST_AW-1:0]  pc_q, pc_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                err_q, err_d;
    logic [INST_W-1:0]   inst_q, inst_d;
    logic                llr_wr_q, llr_wr_d;
    logic                bit_wr_q, bit_wr_d;
    logic [ROW_AW-1:0]   wr_addr_q, wr_addr_d;
    logic [15:0]         frame_cnt_q, frame_cnt_d;

    logic dec_llr_wr, dec_bit_wr, dec_is_end;

    pu_inst_sequencer_decode u_decode (
        .opcode_i (inst_rdata_i[PU_OP_LOCATION +: 4]),
        .llr_wr_o (dec_llr_wr),
        .bit_wr_o (dec_bit_wr),
        .is_end_o (dec_is_end)
    );

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        busy_d        = busy_q;
        done_d        = 1'b0;
        err_d         = err_q;
        inst_d        = inst_q;
        llr_wr_d      = llr_wr_q;
        bit_wr_d      = bit_wr_q;
        wr_addr_d     = wr_addr_q;
        frame_cnt_d   = frame_cnt_q;
        inst_rd_en_o  = 1'b0;
        llr_rd_en_o   = 1'b0;
        llr_rd_addr_o = '0;
        unique case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    state_d = ST_FETCH;
                    pc_d    = '0;
                    err_d   = 1'b0;
                    busy_d  = 1'b1;
                end
            end
            ST_FETCH: begin
                inst_rd_en_o = 1'b1;
                state_d      = ST_LOAD;
            end
            ST_LOAD: begin
                inst_d    = inst_rdata_i;
                wr_addr_d = inst_rdata_i[DST_ROW_LOCATION +: ROW_AW];
                if (dec_is_end) begin
                    done_d  = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    llr_rd_en_o   = 1'b1;
                    llr_rd_addr_o = inst_rdata_i[SRC_ROW_LOCATION +: ROW_AW];
                    llr_wr_d      = dec_llr_wr;
                    bit_wr_d      = dec_bit_wr;
                    state_d       = ST_EXEC;
                end
            end
            ST_EXEC: begin
                // Under hold every register keeps its value; the write strobe is
                // masked at the output until the cycle hold drops.
                if (!hold_i) begin
                    llr_wr_d = 1'b0;
                    bit_wr_d = 1'b0;
                    pc_d     = pc_q + 1'b1;
                    if (pc_q == '1) begin
                        err_d   = 1'b1;
                        done_d  = 1'b1;
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_FETCH;
                    end
                end
            end
            ST_DONE: begin
                busy_d  = 1'b0;
                if (!err_q) frame_cnt_d = frame_cnt_q + 16'd1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            pc_q        <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            inst_q      <= '0;
            llr_wr_q    <= 1'b0;
            bit_wr_q    <= 1'b0;
            wr_addr_q   <= '0;
            frame_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
            inst_q      <= inst_d;
            llr_wr_q    <= llr_wr_d;
            bit_wr_q    <= bit_wr_d;
            wr_addr_q   <= wr_addr_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign err_o       = err_q;
    assign inst_addr_o = pc_q;
    assign pu_inst_o   = inst_q;
    assign wr_addr_o   = wr_addr_q;
    assign frame_cnt_o = frame_cnt_q;
    assign llr_wr_en_o = llr_wr_q & ~hold_i;
    assign bit_wr_en_o = bit_wr_q & ~hold_i;

endmodule

// File: tb/tb_pu_inst_sequencer.sv
// Scoreboard bench: a program-level model schedules expected writes and done
// pulses by absolute cycle; a negedge monitor pops and compares them.
module tb_pu_inst_sequencer;
    import pu_inst_sequencer_pkg::*;

    logic        clk = 1'b0;
    logic        rst, start_s, hold_s;
    logic        busy, done, err, inst_rd_en, llr_rd_en, llr_wr_en, bit_wr_en;
    logic [7:0]  inst_addr;
    logic [15:0] inst_rdata, pu_inst, frame_cnt;
    logic [3:0]  llr_rd_addr, wr_addr;

    pu_inst_sequencer dut (
        .clk(clk), .rst(rst), .start_i(start_s), .hold_i(hold_s),
        .busy_o(busy), .done_o(done), .err_o(err),
        .inst_rd_en_o(inst_rd_en), .inst_addr_o(inst_addr), .inst_rdata_i(inst_rdata),
        .pu_inst_o(pu_inst), .llr_rd_en_o(llr_rd_en), .llr_rd_addr_o(llr_rd_addr),
        .llr_wr_en_o(llr_wr_en), .bit_wr_en_o(bit_wr_en), .wr_addr_o(wr_addr),
        .frame_cnt_o(frame_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          kind;   // 0 llr write, 1 bit write, 2 done
        int          cyc;
        logic [15:0] inst;
        logic        err;
    } item_t;

    localparam int HMAX = 8192;

    int          checks = 0, errors = 0, cyc = 0, done_count = 0, exp_frames = 0;
    logic [15:0] rom [0:255];
    int          hold_cnt [0:255];
    bit          hold_sched [0:HMAX-1];
    logic [15:0] hold_inst [0:HMAX-1];
    item_t       exp_q [$];

    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) if (inst_rd_en) inst_rdata <= rom[inst_addr];
    always @(posedge clk) begin
        #1;
        hold_s = (cyc < HMAX) ? hold_sched[cyc] : 1'b0;
    end

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endfunction

    // Monitor: every write strobe or done pulse must match the head of the queue.
    always @(negedge clk) begin
        item_t it;
        int    kind;
        if (!rst) begin
            if (cyc < HMAX && hold_sched[cyc]) begin
                chk("hold_pu_inst", pu_inst, hold_inst[cyc]);
                chk("hold_wr_addr", wr_addr, hold_inst[cyc][14:11]);
            end
            if (llr_wr_en && bit_wr_en) chk("both_wr_en", 1, 0);
            if (llr_wr_en || bit_wr_en || done) begin
                kind = done ? 2 : (llr_wr_en ? 0 : 1);
                if (done) done_count++;
                if (exp_q.size() == 0) begin
                    chk("unexpected_event_kind", kind, 99);
                end else begin
                    it = exp_q.pop_front();
                    $display("txn cyc=%0d kind=%0d pu_inst=%04h wr_addr=%0d err=%0b",
                             cyc, kind, pu_inst, wr_addr, err);
                    chk("event_kind", kind, it.kind);
                    chk("event_cycle", cyc, it.cyc);
                    if (it.kind == 2) begin
                        chk("done_err", err, it.err);
                    end else begin
                        chk("wr_pu_inst", pu_inst, it.inst);
                        chk("wr_addr", wr_addr, it.inst[14:11]);
                    end
                end
            end
        end
    end

    function automatic void push(input int kind, input int c, input logic [15:0] ins, input logic e);
        item_t it;
        it.kind = kind; it.cyc = c; it.inst = ins; it.err = e;
        exp_q.push_back(it);
    endfunction

    // Program-level model: each executed instruction costs 3 cycles plus its
    // hold time; END costs FETCH+LOAD then DONE; running past pc 255 is an error.
    task automatic model_frame(input int s, output bit werr);
        int t, e, pc;
        logic [15:0] ins;
        logic [3:0]  op;
        t = s; pc = 0; werr = 1'b0;
        forever begin
            ins = rom[pc];
            op  = ins[3:0];
            if (op == 4'hF) begin
                push(2, t + 3, ins, 1'b0);
                break;
            end
            e = t + 3;
            for (int j = 0; j < hold_cnt[pc]; j++) begin
                hold_sched[e + j] = 1'b1;
                hold_inst[e + j]  = ins;
            end
            t = e + hold_cnt[pc];
            if (op <= 4'd1)      push(0, t, ins, 1'b0);
            else if (op <= 4'd8) push(1, t, ins, 1'b0);
            if (pc == 255) begin
                werr = 1'b1;
                push(2, t + 1, ins, 1'b1);
                break;
            end
            pc++;
        end
    endtask

    task automatic clear_prog();
        for (int i = 0; i < 256; i++) begin
            rom[i] = 16'hFFFF;
            hold_cnt[i] = 0;
        end
    endtask

    task automatic set_inst(input int idx, input logic [3:0] op, input logic [3:0] src, input logic [3:0] dst);
        logic [2:0] stage;
        stage = 3'($urandom_range(0, 7));
        rom[idx] = {1'b0, dst, src, stage, op};
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_err"}, err, 0);
        chk({tag, "_inst_rd_en"}, inst_rd_en, 0);
        chk({tag, "_inst_addr"}, inst_addr, 0);
        chk({tag, "_pu_inst"}, pu_inst, 0);
        chk({tag, "_llr_rd_en"}, llr_rd_en, 0);
        chk({tag, "_llr_rd_addr"}, llr_rd_addr, 0);
        chk({tag, "_llr_wr_en"}, llr_wr_en, 0);
        chk({tag, "_bit_wr_en"}, bit_wr_en, 0);
        chk({tag, "_wr_addr"}, wr_addr, 0);
        chk({tag, "_frame_cnt"}, frame_cnt, 0);
    endtask

    task automatic run_frame(input bit busy_start);
        int s, d0;
        bit werr;
        d0 = done_count;
        @(posedge clk); #1;
        s = cyc;
        model_frame(s, werr);
        start_s = 1'b1;
        @(posedge clk); #1;
        start_s = 1'b0;
        @(negedge clk);
        chk("fetch_busy", busy, 1);
        chk("fetch_err_cleared", err, 0);
        chk("fetch_inst_rd_en", inst_rd_en, 1);
        chk("fetch_inst_addr", inst_addr, 0);
        @(posedge clk); #1;
        if (busy_start) start_s = 1'b1;
        @(negedge clk);
        chk("load_llr_rd_en", llr_rd_en, (rom[0][3:0] != 4'hF) ? 1 : 0);
        if (rom[0][3:0] != 4'hF) chk("load_llr_rd_addr", llr_rd_addr, rom[0][10:7]);
        @(posedge clk); #1;
        start_s = 1'b0;
        for (int k = 0; k < 3000 && done_count == d0; k++) @(posedge clk);
        if (done_count == d0) begin
            chk("done_timeout", 0, 1);
            exp_q.delete();
        end
        if (!werr) exp_frames++;
        @(negedge clk);
        chk("idle_busy", busy, 0);
        chk("idle_err", err, werr);
        chk("idle_frame_cnt", frame_cnt, 32'(exp_frames[15:0]));
        chk("queue_empty", exp_q.size(), 0);
    endtask

    task automatic prog_t1();
        clear_prog();
        set_inst(0, FUNC_F, 4'd1, 4'd2);
        set_inst(1, FUNC_G, 4'd1, 4'd3);
        set_inst(2, OP_END, 4'd0, 4'd0);
    endtask

    initial begin
        int  s, n;
        bit  werr;
        logic [3:0] op;
        rst = 1'b0; start_s = 1'b0;
        for (int i = 0; i < HMAX; i++) hold_sched[i] = 1'b0;
        clear_prog();
        #2 rst = 1'b1;
        #1 check_zero("reset");
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        prog_t1();
        run_frame(1'b0);

        clear_prog();
        set_inst(0, FUNC_REP, 4'd2, 4'd4);
        set_inst(1, FUNC_SPC, 4'd3, 4'd5);
        set_inst(2, FUNC_RATE1, 4'd6, 4'd7);
        set_inst(3, FUNC_COMB, 4'd8, 4'd9);
        set_inst(4, OP_END, 4'd0, 4'd0);
        run_frame(1'b0);

        clear_prog();
        set_inst(0, FUNC_F, 4'd5, 4'd6);
        hold_cnt[0] = 5;
        set_inst(1, FUNC_REP, 4'd7, 4'd8);
        set_inst(2, OP_END, 4'd0, 4'd0);
        run_frame(1'b0);

        clear_prog();
        for (int i = 0; i < 256; i++) set_inst(i, OP_NOP, 4'($urandom), 4'($urandom));
        run_frame(1'b0);

        prog_t1();
        run_frame(1'b1);

        // Asynchronous reset in the first EXEC cycle aborts the frame.
        prog_t1();
        @(posedge clk); #1;
        s = cyc;
        model_frame(s, werr);
        start_s = 1'b1;
        @(posedge clk); #1;
        start_s = 1'b0;
        while (cyc < s + 3) @(negedge clk);
        #2 rst = 1'b1;
        #1 check_zero("midframe_reset");
        exp_q.delete();
        exp_frames = 0;
        @(posedge clk); #1;
        rst = 1'b0;
        run_frame(1'b0);

        repeat (20) begin
            clear_prog();
            n = $urandom_range(0, 12);
            for (int i = 0; i < n; i++) begin
                op = 4'($urandom_range(0, 14));
                set_inst(i, op, 4'($urandom), 4'($urandom));
                rom[i][15] = 1'($urandom);
                hold_cnt[i] = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : 0;
            end
            set_inst(n, OP_END, 4'($urandom), 4'($urandom));
            run_frame(1'($urandom_range(0, 1)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout at cycle %0d", cyc);
        $fatal(1, "timeout");
    end

endmodule
